// File: rtl/track_trellis.sv
// ============================================================================
//  Module      : track_trellis
//  Description : One Viterbi traceback step for the rate-1/2, K=3 code.
//                Returns the predecessor state and the decoded bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module track_trellis (
    input  logic       clk,
    input  logic       rst,
    input  logic       st,
    input  logic [1:0] node,
    input  logic [1:0] flag,
    output logic [1:0] next_node,
    output logic       data_out,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_latch;
    logic       w_compute;
    logic       w_emit;

    logic [1:0] r_node;
    logic [1:0] r_flag;
    logic [1:0] r_pred;
    logic       r_bit;
    logic [1:0] r_next_node;
    logic       r_data_out;
    logic       r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_compute   = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (st) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_compute   = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                w_emit      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_node      <= 2'b00;
            r_flag      <= 2'b00;
            r_pred      <= 2'b00;
            r_bit       <= 1'b0;
            r_next_node <= 2'b00;
            r_data_out  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_emit;
            if (w_latch) begin
                r_node <= node;
                r_flag <= flag;
            end
            // Predecessor drops the newest bit and shifts in the survivor decision;
            // tail steps always decode to zero.
            if (w_compute) begin
                r_pred <= {r_node[0], r_flag[0]};
                r_bit  <= r_flag[1] ? 1'b0 : r_node[1];
            end
            if (w_emit) begin
                r_next_node <= r_pred;
                r_data_out  <= r_bit;
            end
        end
    end

    assign next_node = r_next_node;
    assign data_out  = r_data_out;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_track_trellis.sv
// ============================================================================
//  Module      : tb_track_trellis
//  Description : Directed self-checking bench for track_trellis.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_track_trellis;

    logic       clk;
    logic       rst;
    logic       st;
    logic [1:0] node;
    logic [1:0] flag;
    logic [1:0] next_node;
    logic       data_out;
    logic       done;

    int checks   = 0;
    int failures = 0;

    track_trellis dut (
        .clk       (clk),
        .rst       (rst),
        .st        (st),
        .node      (node),
        .flag      (flag),
        .next_node (next_node),
        .data_out  (data_out),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_pred(input logic [1:0] n, input logic [1:0] f);
        return {n[0], f[0]};
    endfunction

    function automatic logic m_bit(input logic [1:0] n, input logic [1:0] f);
        return f[1] ? 1'b0 : n[1];
    endfunction

    // One full step: sample at the first edge, scramble inputs afterwards,
    // expect done only after the third edge.
    task automatic step(input string tag, input logic [1:0] n, input logic [1:0] f);
        st = 1'b1; node = n; flag = f;
        tick();
        st = 1'b0; node = ~n; flag = ~f;
        check({tag, "_done_c1"}, {1'b0, done}, 2'b00);
        tick();
        check({tag, "_done_c2"}, {1'b0, done}, 2'b00);
        tick();
        check({tag, "_done"}, {1'b0, done}, 2'b01);
        check({tag, "_next_node"}, next_node, m_pred(n, f));
        check({tag, "_data_out"}, {1'b0, data_out}, {1'b0, m_bit(n, f)});
        tick();
        check({tag, "_done_drop"}, {1'b0, done}, 2'b00);
        check({tag, "_hold_nn"}, next_node, m_pred(n, f));
    endtask

    initial begin
        rst = 1'b1; st = 1'b0; node = 2'b11; flag = 2'b11;
        tick();
        check("rst_next_node", next_node, 2'b00);
        check("rst_data_out", {1'b0, data_out}, 2'b00);
        check("rst_done", {1'b0, done}, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_no_done", {1'b0, done}, 2'b00);
        end

        step("t2_n10_f00", 2'b10, 2'b00);
        step("t3_n01_f01", 2'b01, 2'b01);
        step("t3_n11_f01", 2'b11, 2'b01);
        step("t4_n10_f10", 2'b10, 2'b10);
        step("t4_n11_f11", 2'b11, 2'b11);

        // Continuous run with st held: done every third cycle.
        st = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [1:0] n;
            logic [1:0] f;
            n = k[3:2];
            f = k[1:0];
            node = n; flag = f;
            tick();
            node = ~n; flag = ~f;
            check("sweep_done_c1", {1'b0, done}, 2'b00);
            tick();
            check("sweep_done_c2", {1'b0, done}, 2'b00);
            tick();
            check("sweep_done", {1'b0, done}, 2'b01);
            check("sweep_next_node", next_node, m_pred(n, f));
            check("sweep_data_out", {1'b0, data_out}, {1'b0, m_bit(n, f)});
        end
        st = 1'b0;
        tick();
        check("sweep_end_done", {1'b0, done}, 2'b00);

        // Leave nonzero outputs, then reset while in LOAD.
        step("pre_abort", 2'b11, 2'b01);
        st = 1'b1; node = 2'b01; flag = 2'b01;
        tick();
        st = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_next_node", next_node, 2'b00);
        check("abort_data_out", {1'b0, data_out}, 2'b00);
        check("abort_done", {1'b0, done}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_done", {1'b0, done}, 2'b00);
        end
        step("restart", 2'b01, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
